uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- Byte-stream-to-bus bridge. Acts as a second initiator on the SoC valid/ready memory bus: addr/size/valid/write/wdata/rdata/ready.
- Takes serial command frames from a tty_rx-style byte source and issues one bus transaction per frame. Returns the result bytes to a tty_tx-style byte sink.
- Used for debug peek/poke and for loading RAM (0x1000–0x1FFF) or touching stdio (0x3000/0x3004) from a host while the core is held or idle.

Parameters:
- TIMEOUT, 1024, bus cycles to wait for ready before aborting a transaction (range 2..65535).
- ACK_BYTE, 8'h4B, response byte for a successful write.
- ERR_BYTE, 8'h45, response byte for an illegal command.
- TMO_BYTE, 8'h54, response byte for a bus timeout.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  command byte from the receiver
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  block accepts rx_data this cycle
- tx_data  output  8  response byte to the transmitter
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  transmitter accepts tx_data this cycle
- addr  output  32  bus address
- size  output  3  0 = byte, 1 = half, 2 = word
- valid  output  1  bus request
- write  output  1  1 = write, 0 = read
- wdata  output  32  write data, LSB-justified (responder aligns it)
- rdata  input  32  read data, LSB-justified
- ready  input  1  responder completes the transfer
- busy  output  1  high in any state other than CMD

Behaviour:
- Reset: rst asynchronously forces state CMD, all registers to 0, rx_ready=1, tx_valid=0, valid=0, write=0, addr=0, size=0, wdata=0, busy=0.
  - Reset mid-transaction drops valid immediately. No response is sent for the aborted frame.
- Byte handshakes: a byte transfers on a cycle where valid&&ready. rx_ready is 1 only in CMD/ADDR/WDATA. tx_data and tx_valid hold until tx_ready.
- Frame format: CMD byte, then 4 address bytes (little-endian), then N data bytes (little-endian, write only), with N = 1/2/4 for size 0/1/2.
  - CMD[7] = write.
  - CMD[1:0] = size.
  - CMD[6:2] are ignored.
- States:
  - CMD: accept a byte and latch write and size.
    - CMD[1:0]==3: go to RESP with ERR_BYTE. The frame is dropped and no address bytes are consumed.
    - Otherwise: go to ADDR with byte counter = 0.
  - ADDR: each accepted byte is stored at addr[8*cnt +: 8] and cnt increments. On the 4th byte, go to WDATA (write) or BUS (read), with cnt reset to 0.
  - WDATA: wdata is cleared on entry. Each byte is stored at wdata[8*cnt +: 8]. After N bytes, go to BUS. Unused upper wdata bits stay 0.
  - BUS: valid=1 starting the cycle after the last frame byte. addr, size, write and wdata are stable while valid=1.
    - On valid&&ready: capture rdata (read), drop valid next cycle, then go to RESP. A write loads ACK_BYTE; a read loads byte 0 of the captured rdata.
    - Timeout counter clears on entry and counts cycles with valid&&!ready. When it reaches TIMEOUT-1 without ready: valid drops, go to RESP with TMO_BYTE. No data bytes are sent.
    - Ready in the same cycle the count reaches TIMEOUT-1 counts as success.
  - RESP: tx_valid=1 with the current byte.
    - On tx_ready for a read: advance through bytes 1..N-1 of the captured rdata, then go to CMD.
    - Write, error and timeout send a single byte, then go to CMD.
- Read data is returned LSB-first, N bytes. Bits of rdata above 8*N are ignored.
- No pipelining: one outstanding transaction at a time. The next CMD byte is accepted no earlier than the cycle after the last response byte transfers.
- rx bytes arriving in BUS/RESP are back-pressured (rx_ready=0), never dropped.
- addr is not checked for alignment or range; that is the responder/decoder's job.

Decomposition:
- Shared package uart_bus_pkg holds:
  - typedef of state enum {CMD, ADDR, WDATA, BUS, RESP};
  - size encoding constants SZ_B=0, SZ_H=1, SZ_W=2;
  - CMD bit positions;
  - default response bytes.
- One sub-module, ubm_timeout: a loadable down-counter with clear/enable/expired, width $clog2(TIMEOUT). The rest stays flat.

Test Plan:
- Word write: rx 0x82,00,10,00,00,EF,BE,AD,DE with ready responding in 1 cycle -> one valid pulse with addr=0x00001000, size=2, write=1, wdata=0xDEADBEEF; tx 0x4B.
- Half read: rx 0x01,04,10,00,00 with rdata=0x12345678 and ready after 3 cycles -> size=1, write=0, valid held 3 cycles; tx 0x78,0x56; then rx_ready=1.
- Byte write to stdout: rx 0x80,00,30,00,00,41 -> addr=0x3000, size=0, wdata=0x00000041; tx 0x4B.
- Illegal size: rx 0x03 -> no valid; tx 0x45; the next byte 0x02 is parsed as a new CMD.
- Timeout: TIMEOUT=16, read with ready held 0 -> valid high exactly 15 cycles then low; tx 0x54; no data bytes.
- Back-pressure/reset: tx_ready held 0 during read response -> tx_data stable and rx_ready=0; assert rst mid-BUS -> valid=0 same cycle, tx_valid=0, and a following frame completes normally.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// rtl/uart_bus_pkg.sv - shared types and constants for the byte-stream bus master
package uart_bus_pkg;

   typedef enum logic [2:0] {
      CMD,
      ADDR,
      WDATA,
      BUS,
      RESP
   } state_t;

   localparam logic [1:0] SZ_B   = 2'd0;
   localparam logic [1:0] SZ_H   = 2'd1;
   localparam logic [1:0] SZ_W   = 2'd2;
   localparam logic [1:0] SZ_BAD = 2'd3;

   localparam int CMD_WRITE_BIT = 7;
   localparam int CMD_SIZE_LSB  = 0;
   localparam int CMD_SIZE_MSB  = 1;

   localparam logic [7:0] DEF_ACK_BYTE = 8'h4B;
   localparam logic [7:0] DEF_ERR_BYTE = 8'h45;
   localparam logic [7:0] DEF_TMO_BYTE = 8'h54;

   // Index of the last data byte of a transfer (N-1 for N = 1/2/4).
   function automatic logic [1:0] last_idx(input logic [1:0] sz);
      case (sz)
         SZ_B:    last_idx = 2'd0;
         SZ_H:    last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// rtl/uart_bus_master_if.sv - valid/ready memory bus seen from the bridge
interface uart_bus_master_if;
   logic [31:0] addr;
   logic [2:0]  size;
   logic        valid;
   logic        write;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (
      output addr, size, valid, write, wdata,
      input  rdata, ready
   );

   modport slave (
      input  addr, size, valid, write, wdata,
      output rdata, ready
   );
endinterface

// File: rtl/ubm_timeout.sv
// rtl/ubm_timeout.sv - loadable down-counter that flags a stalled bus transfer
module ubm_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT);
   // Loaded with TIMEOUT-2 so that the cycle in which the stall count would
   // reach TIMEOUT-1 is the one where expired is seen alongside enable.
   localparam logic [W-1:0] LOAD = W'(TIMEOUT - 2);

   logic [W-1:0] count;

   // Reload while idle, count down each stalled cycle, park at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= LOAD;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);
endmodule

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - serial command frames in, one bus transaction out, result bytes back
module uart_bus_master
   import uart_bus_pkg::*;
#(
   parameter int         TIMEOUT  = 1024,
   parameter logic [7:0] ACK_BYTE = DEF_ACK_BYTE,
   parameter logic [7:0] ERR_BYTE = DEF_ERR_BYTE,
   parameter logic [7:0] TMO_BYTE = DEF_TMO_BYTE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   uart_bus_master_if.master bus,
   output logic              busy
);
   state_t      state, state_n;
   logic [1:0]  cnt;
   logic        write_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] resp_q;
   logic        bus_valid;
   logic        rx_fire;
   logic        tx_fire;
   logic        tmo_clear;
   logic        tmo_enable;
   logic        tmo_expired;
   logic        tmo_hit;
   logic [1:0]  last;
   logic        unused_cmd_bits;

   // CMD[6:2] carry no meaning in the frame format.
   assign unused_cmd_bits = ^rx_data[6:2];

   assign last       = last_idx(size_q);
   assign rx_fire    = rx_valid && rx_ready;
   assign tx_fire    = tx_valid && tx_ready;
   assign tmo_clear  = (state != BUS);
   assign tmo_enable = (state == BUS) && !bus.ready;
   assign tmo_hit    = tmo_enable && tmo_expired;

   ubm_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CMD;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and handshake outputs; valid is decoded from state so a
   // reset drops it in the same cycle.
   always_comb begin
      state_n   = state;
      rx_ready  = 1'b0;
      tx_valid  = 1'b0;
      bus_valid = 1'b0;
      case (state)
         CMD: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               state_n = (rx_data[CMD_SIZE_MSB:CMD_SIZE_LSB] == SZ_BAD) ? RESP : ADDR;
            end
         end
         ADDR: begin
            rx_ready = 1'b1;
            if (rx_valid && (cnt == 2'd3)) begin
               state_n = write_q ? WDATA : BUS;
            end
         end
         WDATA: begin
            rx_ready = 1'b1;
            if (rx_valid && (cnt == last)) begin
               state_n = BUS;
            end
         end
         BUS: begin
            bus_valid = 1'b1;
            if (bus.ready || tmo_hit) begin
               state_n = RESP;
            end
         end
         RESP: begin
            tx_valid = 1'b1;
            if (tx_ready && (cnt == 2'd0)) begin
               state_n = CMD;
            end
         end
         default: state_n = CMD;
      endcase
   end

   // Frame assembly, bus result capture and response byte sequencing.
   // In RESP, cnt holds the number of bytes still to follow the current one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 2'd0;
         write_q <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         resp_q  <= 32'd0;
      end else begin
         case (state)
            CMD: begin
               if (rx_fire) begin
                  write_q <= rx_data[CMD_WRITE_BIT];
                  size_q  <= rx_data[CMD_SIZE_MSB:CMD_SIZE_LSB];
                  cnt     <= 2'd0;
                  if (rx_data[CMD_SIZE_MSB:CMD_SIZE_LSB] == SZ_BAD) begin
                     resp_q <= {24'd0, ERR_BYTE};
                  end
               end
            end
            ADDR: begin
               if (rx_fire) begin
                  addr_q[8*cnt +: 8] <= rx_data;
                  cnt                <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     wdata_q <= 32'd0;
                  end
               end
            end
            WDATA: begin
               if (rx_fire) begin
                  wdata_q[8*cnt +: 8] <= rx_data;
                  cnt                 <= (cnt == last) ? 2'd0 : cnt + 2'd1;
               end
            end
            BUS: begin
               if (bus.ready) begin
                  if (write_q) begin
                     resp_q <= {24'd0, ACK_BYTE};
                     cnt    <= 2'd0;
                  end else begin
                     resp_q <= bus.rdata;
                     cnt    <= last;
                  end
               end else if (tmo_hit) begin
                  resp_q <= {24'd0, TMO_BYTE};
                  cnt    <= 2'd0;
               end
            end
            RESP: begin
               if (tx_fire) begin
                  resp_q <= resp_q >> 8;
                  if (cnt != 2'd0) begin
                     cnt <= cnt - 2'd1;
                  end
               end
            end
            default: cnt <= 2'd0;
         endcase
      end
   end

   assign tx_data   = resp_q[7:0];
   assign busy      = (state != CMD);
   assign bus.addr  = addr_q;
   assign bus.size  = {1'b0, size_q};
   assign bus.valid = bus_valid;
   assign bus.write = write_q;
   assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - scoreboard bench for uart_bus_master
module tb_uart_bus_master;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  size;
      logic        write;
      logic [31:0] wdata;
   } txn_t;

   typedef logic [7:0] byte_q_t[$];

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   uart_bus_master_if bus_if();

   uart_bus_master #(.TIMEOUT(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .bus      (bus_if),
      .busy     (busy)
   );

   int          total  = 0;
   int          passed = 0;
   logic [7:0]  exp_tx[$];
   int          exp_len[$];
   txn_t        exp_txn[$];
   int          hold = 1;
   logic [31:0] rdata_val = 32'd0;
   int          vcnt = 0;
   txn_t        cur;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   // Bus responder: checks each request against the scoreboard, holds it for
   // `hold` valid cycles (0 = never ready), checks how long valid stayed up.
   always @(negedge clk) begin
      if (rst) begin
         vcnt = 0;
         bus_if.ready = 1'b0;
      end else if (bus_if.valid) begin
         vcnt++;
         if (vcnt == 1) begin
            chk("txn_expected", 32'(exp_txn.size() != 0), 32'd1);
            if (exp_txn.size() != 0) begin
               cur = exp_txn.pop_front();
               chk("bus_addr", bus_if.addr, cur.addr);
               chk("bus_size", 32'(bus_if.size), 32'(cur.size));
               chk("bus_write", 32'(bus_if.write), 32'(cur.write));
               if (cur.write) chk("bus_wdata", bus_if.wdata, cur.wdata);
            end
            cur.wdata = bus_if.wdata;
         end else begin
            chk("stable_addr", bus_if.addr, cur.addr);
            chk("stable_size", 32'(bus_if.size), 32'(cur.size));
            chk("stable_wdata", bus_if.wdata, cur.wdata);
         end
         bus_if.ready = (hold != 0) && (vcnt == hold);
         bus_if.rdata = rdata_val;
      end else begin
         if (vcnt != 0) begin
            chk("len_expected", 32'(exp_len.size() != 0), 32'd1);
            if (exp_len.size() != 0) chk("valid_len", 32'(vcnt), 32'(exp_len.pop_front()));
         end
         vcnt = 0;
         bus_if.ready = 1'b0;
      end
   end

   // Response monitor: every transferred tx byte must match the scoreboard.
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
         if (exp_tx.size() != 0) chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rx_accept_in_time", 32'(n < 100), 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input byte_q_t f);
      foreach (f[i]) send_byte(f[i]);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy !== 1'b0 || exp_tx.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("idle_in_time", 32'(n < 500), 32'd1);
      chk("tx_all_seen", 32'(exp_tx.size()), 32'd0);
      chk("len_all_seen", 32'(exp_len.size()), 32'd0);
      chk("txn_all_seen", 32'(exp_txn.size()), 32'd0);
   endtask

   initial begin
      byte_q_t fr;
      int      n;
      logic [7:0] held;

      rst = 1'b1;
      rx_data = 8'd0;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      bus_if.ready = 1'b0;
      bus_if.rdata = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_rx_ready", 32'(rx_ready), 32'd1);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_valid", 32'(bus_if.valid), 32'd0);
      chk("rst_write", 32'(bus_if.write), 32'd0);
      chk("rst_addr", bus_if.addr, 32'd0);
      chk("rst_size", 32'(bus_if.size), 32'd0);
      chk("rst_wdata", bus_if.wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Word write, ready on the first valid cycle.
      hold = 1;
      exp_txn.push_back('{addr: 32'h0000_1000, size: 3'd2, write: 1'b1, wdata: 32'hDEAD_BEEF});
      exp_len.push_back(1);
      exp_tx.push_back(8'h4B);
      fr = '{8'h82, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_frame(fr);
      wait_idle();

      // Half read, ready on the third valid cycle, two bytes LSB first.
      hold = 3;
      rdata_val = 32'h1234_5678;
      exp_txn.push_back('{addr: 32'h0000_1004, size: 3'd1, write: 1'b0, wdata: 32'd0});
      exp_len.push_back(3);
      exp_tx.push_back(8'h78);
      exp_tx.push_back(8'h56);
      fr = '{8'h01, 8'h04, 8'h10, 8'h00, 8'h00};
      send_frame(fr);
      wait_idle();
      chk("half_read_rx_ready", 32'(rx_ready), 32'd1);

      // Byte write to stdout; upper wdata bits must be zero.
      hold = 1;
      exp_txn.push_back('{addr: 32'h0000_3000, size: 3'd0, write: 1'b1, wdata: 32'h0000_0041});
      exp_len.push_back(1);
      exp_tx.push_back(8'h4B);
      fr = '{8'h80, 8'h00, 8'h30, 8'h00, 8'h00, 8'h41};
      send_frame(fr);
      wait_idle();

      // Illegal size, then 0x02 starts a fresh word read.
      hold = 2;
      rdata_val = 32'hCAFE_F00D;
      exp_tx.push_back(8'h45);
      exp_txn.push_back('{addr: 32'h0000_1000, size: 3'd2, write: 1'b0, wdata: 32'd0});
      exp_len.push_back(2);
      exp_tx.push_back(8'h0D);
      exp_tx.push_back(8'hF0);
      exp_tx.push_back(8'hFE);
      exp_tx.push_back(8'hCA);
      fr = '{8'h03, 8'h02, 8'h00, 8'h10, 8'h00, 8'h00};
      send_frame(fr);
      wait_idle();

      // Timeout: never ready, valid must stay up exactly TIMEOUT-1 = 15 cycles.
      hold = 0;
      exp_txn.push_back('{addr: 32'h0000_2000, size: 3'd0, write: 1'b0, wdata: 32'd0});
      exp_len.push_back(15);
      exp_tx.push_back(8'h54);
      fr = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
      send_frame(fr);
      wait_idle();

      // Back-pressure on the response: byte holds, rx stays stalled.
      hold = 1;
      rdata_val = 32'hA1B2_C3D4;
      tx_ready = 1'b0;
      exp_txn.push_back('{addr: 32'h0000_1008, size: 3'd1, write: 1'b0, wdata: 32'd0});
      exp_len.push_back(1);
      exp_tx.push_back(8'hD4);
      exp_tx.push_back(8'hC3);
      fr = '{8'h01, 8'h08, 8'h10, 8'h00, 8'h00};
      send_frame(fr);
      n = 0;
      while (tx_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("resp_in_time", 32'(n < 100), 32'd1);
      held = 8'hD4;
      repeat (4) begin
         @(negedge clk);
         chk("bp_tx_valid", 32'(tx_valid), 32'd1);
         chk("bp_tx_data", 32'(tx_data), 32'(held));
         chk("bp_rx_ready", 32'(rx_ready), 32'd0);
      end
      @(posedge clk);
      #2 tx_ready = 1'b1;
      @(negedge clk);
      wait_idle();

      // Reset in the middle of a bus transfer.
      hold = 0;
      exp_txn.push_back('{addr: 32'h0000_1100, size: 3'd2, write: 1'b0, wdata: 32'd0});
      fr = '{8'h02, 8'h00, 8'h11, 8'h00, 8'h00};
      send_frame(fr);
      repeat (2) @(negedge clk);
      chk("pre_rst_valid", 32'(bus_if.valid), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus_if.valid), 32'd0);
      chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);

      // A normal frame after the reset.
      hold = 1;
      exp_txn.push_back('{addr: 32'h0000_1010, size: 3'd2, write: 1'b1, wdata: 32'h1122_3344});
      exp_len.push_back(1);
      exp_tx.push_back(8'h4B);
      fr = '{8'h82, 8'h10, 8'h10, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      send_frame(fr);
      wait_idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
